iq_rotation_tracker: RTL
========================

Name: iq_rotation_tracker

Overview:
- Quadrature Doppler direction/rate estimator in the Doppler tracker chain.
- Consumes the moving-averaged sc16 stream ({I,Q}) directly downstream of the complex moving-average stage.
- Tracks quadrant transitions of the I/Q phasor with per-axis hysteresis and emits one signed period word per full rotation.
  - Positive word: counter-clockwise rotation (positive Doppler).
  - Negative word: clockwise rotation.
  - Zero: timeout with no rotation.

Parameters:
- WIDTH, 16, bits per I and Q component.
- COUNTER_SIZE, 32, width of the period counter and of o_tdata.

Ports:
- ce_clk  in  1  block clock; all logic on rising edge. One clock only.
- ce_rst  in  1  synchronous, active-high reset.
- clear  in  1  synchronous soft clear of tracking state; configuration inputs unaffected.
- hysteresis  in  WIDTH  unsigned dead band around zero per axis.
- offset_i  in  WIDTH  signed DC bias subtracted from I.
- offset_q  in  WIDTH  signed DC bias subtracted from Q.
- timeout  in  COUNTER_SIZE  samples without a rotation before a zero word is emitted; 0 disables.
- i_tdata  in  2*WIDTH  {I[31:16], Q[15:0]}, signed.
- i_tlast  in  1  ignored.
- i_tvalid  in  1  input valid.
- i_tready  out  1  input ready.
- o_tdata  out  COUNTER_SIZE  signed period in samples.
- o_tlast  out  1  end of packet; every output word is a one-word packet.
- o_tvalid  out  1  output valid.
- o_tready  in  1  output ready.
- rot_count  out  32  signed net rotations since reset/clear.
- status  out  16  {drop_cnt[15:8], sync_err_cnt[7:0]}.

Behaviour:
- Reset values:
  - i_tready=0 while ce_rst=1, then 1 permanently. The input never stalls; sample loss is tolerated.
  - o_tvalid=0, o_tdata=0, o_tlast=0, rot_count=0, status=0, state=ACQUIRE.
- Accepted sample: i_tvalid && i_tready.
- Offset correction:
  - di = I - offset_i and dq = Q - offset_q, computed in WIDTH+1-bit signed arithmetic.
  - No saturation.
- Axis sign with hysteresis (per axis):
  - If d > +hysteresis: sign=positive and known=1.
  - If d < -hysteresis: sign=negative and known=1.
  - Otherwise sign holds.
  - d equal to ±hysteresis holds.
- Quadrant numbering (I,Q): (+,+)=0, (-,+)=1, (-,-)=2, (+,-)=3.
- State ACQUIRE:
  - Period counter held at 0; timeout inactive; no output.
  - On the accepted sample where both axes become known: latch the quadrant, set phase_acc=0 and counter=0, go to TRACK. That sample is not counted.
- State TRACK, per accepted sample:
  - counter += 1, saturating at 2^(COUNTER_SIZE-1)-1.
  - New quadrant minus old quadrant, mod 4:
    - 0: no step.
    - +1: phase_acc += 1.
    - 3: phase_acc -= 1.
    - 2 (both axes flipped in one sample): sync error. sync_err_cnt += 1 (saturating at 255); phase_acc=0; counter=0; no output; new quadrant latched.
  - phase_acc is 4-bit signed.
    - Reaching +4: emit +counter, rot_count += 1.
    - Reaching -4: emit -counter (two's complement), rot_count -= 1.
    - After either emit: phase_acc=0, counter=0.
    - The emitted count includes the completing sample.
  - Timeout: if timeout!=0 and counter == timeout after the increment, with no rotation completed on that sample:
    - Emit 0.
    - counter=0 and phase_acc=0.
    - rot_count unchanged.
  - Rotation completion has priority over timeout on the same sample.
- Output register:
  - An emit loads o_tdata, sets o_tvalid=1 and o_tlast=1 on the clock edge that accepts the sample. Latency is 1 cycle.
  - o_tvalid clears on o_tvalid && o_tready unless a new emit occurs in the same cycle, in which case it stays 1 with the new data.
  - Emit while o_tvalid && !o_tready: the old word is overwritten; drop_cnt += 1 (saturating at 255).
- rot_count wraps modulo 2^32.
- clear:
  - Has the same effect as ce_rst on all state and outputs, except i_tready stays 1.
  - Takes priority over a sample accepted in the same cycle; that sample is discarded.
- Reset or clear mid-rotation discards the partial rotation and returns to ACQUIRE.
- Configuration inputs are sampled every cycle; changing them mid-run takes effect on the next accepted sample.

Test Plan:
- CCW: hysteresis=100, offsets 0, timeout 0. Repeat the 8-sample circle (1000,0),(700,700),(0,1000),(-700,700),(-1000,0),(-700,-700),(0,-1000),(700,-700).
  -> First word +8 after acquisition, then +8 per rotation; rot_count increments; o_tlast=1.
- CW: the same circle in reverse order -> o_tdata=32'hFFFF_FFF8 per rotation; rot_count decrements.
- Hysteresis: after acquiring in quadrant 0, feed I alternating ±50 with hysteresis=100 for 50 samples -> no quadrant change, no output.
- Sync error: jump from (1000,1000) to (-1000,-1000) -> sync_err_cnt=1, no output; the next CCW rotation emits its own count, measured from the error.
- Timeout: timeout=20, constant (1000,1000) after acquisition -> o_tdata=0 on the 20th sample, repeating every 20 samples; rot_count unchanged.
- Backpressure and reset:
  - o_tready=0 over two rotations -> o_tdata holds the second word; drop_cnt=1.
  - Assert ce_rst mid-rotation -> all outputs 0, state ACQUIRE, no stale word after release.

Source files
------------

// File: rtl/iq_rotation_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : iq_rotation_tracker
//  Description : Quadrature Doppler direction/rate estimator. Tracks quadrant
//                transitions of an offset-corrected I/Q phasor with per-axis
//                hysteresis and emits one signed period word per rotation
//                (positive = CCW, negative = CW, zero = timeout).
//  Revision    : 1.0 - initial release
// ============================================================================
module iq_rotation_tracker #(
    parameter int WIDTH        = 16,
    parameter int COUNTER_SIZE = 32
) (
    input  logic                      ce_clk,
    input  logic                      ce_rst,
    input  logic                      clear,
    input  logic [WIDTH-1:0]          hysteresis,
    input  logic [WIDTH-1:0]          offset_i,
    input  logic [WIDTH-1:0]          offset_q,
    input  logic [COUNTER_SIZE-1:0]   timeout,
    input  logic [2*WIDTH-1:0]        i_tdata,
    input  logic                      i_tlast,
    input  logic                      i_tvalid,
    output logic                      i_tready,
    output logic [COUNTER_SIZE-1:0]   o_tdata,
    output logic                      o_tlast,
    output logic                      o_tvalid,
    input  logic                      o_tready,
    output logic [31:0]               rot_count,
    output logic [15:0]               status
);

    localparam int DW = WIDTH + 1;  // offset-corrected component width
    localparam int EW = WIDTH + 2;  // width for comparisons against the band

    localparam logic [0:0] c_ST_ACQUIRE = 1'b0;
    localparam logic [0:0] c_ST_TRACK   = 1'b1;

    localparam logic [COUNTER_SIZE-1:0] c_CNT_ONE = {{(COUNTER_SIZE-1){1'b0}}, 1'b1};
    localparam logic [COUNTER_SIZE-1:0] c_CNT_MAX = {1'b0, {(COUNTER_SIZE-1){1'b1}}};
    localparam logic [3:0]              c_PH_POS4 = 4'b0100;
    localparam logic [3:0]              c_PH_NEG4 = 4'b1100;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [0:0]              r_state;
    logic                    r_ready;
    logic                    r_sign_i, r_sign_q;   // 1 = negative
    logic                    r_known_i, r_known_q;
    logic [1:0]              r_quad;
    logic [3:0]              r_phase;
    logic [COUNTER_SIZE-1:0] r_counter;
    logic [COUNTER_SIZE-1:0] r_out_data;
    logic                    r_out_valid;
    logic                    r_out_last;
    logic [31:0]             r_rot;
    logic [7:0]              r_drop;
    logic [7:0]              r_sync;

    // Next-state values
    logic [0:0]              w_state_nxt;
    logic                    w_sign_i_nxt, w_sign_q_nxt;
    logic                    w_known_i_nxt, w_known_q_nxt;
    logic [1:0]              w_quad_nxt;
    logic [3:0]              w_phase_nxt;
    logic [COUNTER_SIZE-1:0] w_counter_nxt;
    logic [COUNTER_SIZE-1:0] w_out_data_nxt;
    logic                    w_out_valid_nxt;
    logic                    w_out_last_nxt;
    logic [31:0]             w_rot_nxt;
    logic [7:0]              w_drop_nxt;
    logic [7:0]              w_sync_nxt;

    // Datapath helpers
    logic                    w_accept;
    logic                    w_unused;
    logic [WIDTH-1:0]        w_i_raw, w_q_raw;
    logic signed [DW-1:0]    w_di, w_dq;
    logic signed [EW-1:0]    w_di_x, w_dq_x, w_hpos, w_hneg;
    logic                    w_i_pos, w_i_neg, w_q_pos, w_q_neg;
    logic                    w_sign_i_upd, w_sign_q_upd;
    logic                    w_known_i_upd, w_known_q_upd;
    logic [1:0]              w_quad_upd;
    logic [1:0]              w_quad_diff;
    logic [3:0]              w_phase_step;
    logic [COUNTER_SIZE-1:0] w_cnt_inc;
    logic                    w_emit;
    logic [COUNTER_SIZE-1:0] w_emit_data;

    assign w_unused = i_tlast;
    assign w_accept = i_tvalid & r_ready;

    // Offset correction in one extra bit so the subtraction never overflows
    assign w_i_raw = i_tdata[2*WIDTH-1:WIDTH];
    assign w_q_raw = i_tdata[WIDTH-1:0];
    assign w_di    = $signed({w_i_raw[WIDTH-1], w_i_raw}) - $signed({offset_i[WIDTH-1], offset_i});
    assign w_dq    = $signed({w_q_raw[WIDTH-1], w_q_raw}) - $signed({offset_q[WIDTH-1], offset_q});
    assign w_di_x  = {w_di[DW-1], w_di};
    assign w_dq_x  = {w_dq[DW-1], w_dq};
    assign w_hpos  = $signed({2'b00, hysteresis});
    assign w_hneg  = -w_hpos;

    // Strictly outside the dead band; a value exactly on the edge holds
    assign w_i_pos = (w_di_x > w_hpos);
    assign w_i_neg = (w_di_x < w_hneg);
    assign w_q_pos = (w_dq_x > w_hpos);
    assign w_q_neg = (w_dq_x < w_hneg);

    assign w_sign_i_upd  = w_i_pos ? 1'b0 : (w_i_neg ? 1'b1 : r_sign_i);
    assign w_sign_q_upd  = w_q_pos ? 1'b0 : (w_q_neg ? 1'b1 : r_sign_q);
    assign w_known_i_upd = r_known_i | w_i_pos | w_i_neg;
    assign w_known_q_upd = r_known_q | w_q_pos | w_q_neg;

    // (+,+)=0, (-,+)=1, (-,-)=2, (+,-)=3
    assign w_quad_upd   = {w_sign_q_upd, w_sign_i_upd ^ w_sign_q_upd};
    assign w_quad_diff  = w_quad_upd - r_quad;
    assign w_cnt_inc    = (r_counter == c_CNT_MAX) ? r_counter : (r_counter + c_CNT_ONE);
    assign w_phase_step = (w_quad_diff == 2'd1) ? (r_phase + 4'd1) :
                          (w_quad_diff == 2'd3) ? (r_phase - 4'd1) : r_phase;

    // Tracking state machine and period measurement
    always_comb begin
        w_state_nxt   = r_state;
        w_sign_i_nxt  = r_sign_i;
        w_sign_q_nxt  = r_sign_q;
        w_known_i_nxt = r_known_i;
        w_known_q_nxt = r_known_q;
        w_quad_nxt    = r_quad;
        w_phase_nxt   = r_phase;
        w_counter_nxt = r_counter;
        w_rot_nxt     = r_rot;
        w_sync_nxt    = r_sync;
        w_emit        = 1'b0;
        w_emit_data   = '0;

        if (w_accept) begin
            w_sign_i_nxt  = w_sign_i_upd;
            w_sign_q_nxt  = w_sign_q_upd;
            w_known_i_nxt = w_known_i_upd;
            w_known_q_nxt = w_known_q_upd;

            case (r_state)
                c_ST_ACQUIRE: begin
                    if (w_known_i_upd && w_known_q_upd) begin
                        w_state_nxt   = c_ST_TRACK;
                        w_quad_nxt    = w_quad_upd;
                        w_phase_nxt   = 4'd0;
                        w_counter_nxt = '0;
                    end
                end
                c_ST_TRACK: begin
                    w_quad_nxt = w_quad_upd;
                    if (w_quad_diff == 2'd2) begin
                        // Both axes flipped at once: direction is ambiguous
                        if (r_sync != 8'hFF) w_sync_nxt = r_sync + 8'd1;
                        w_phase_nxt   = 4'd0;
                        w_counter_nxt = '0;
                    end else if (w_phase_step == c_PH_POS4) begin
                        w_emit        = 1'b1;
                        w_emit_data   = w_cnt_inc;
                        w_rot_nxt     = r_rot + 32'd1;
                        w_phase_nxt   = 4'd0;
                        w_counter_nxt = '0;
                    end else if (w_phase_step == c_PH_NEG4) begin
                        w_emit        = 1'b1;
                        w_emit_data   = (~w_cnt_inc) + c_CNT_ONE;
                        w_rot_nxt     = r_rot - 32'd1;
                        w_phase_nxt   = 4'd0;
                        w_counter_nxt = '0;
                    end else if ((timeout != '0) && (w_cnt_inc == timeout)) begin
                        w_emit        = 1'b1;
                        w_emit_data   = '0;
                        w_phase_nxt   = 4'd0;
                        w_counter_nxt = '0;
                    end else begin
                        w_phase_nxt   = w_phase_step;
                        w_counter_nxt = w_cnt_inc;
                    end
                end
                default: w_state_nxt = c_ST_ACQUIRE;
            endcase
        end
    end

    // Output word register with overwrite-on-stall and drop accounting
    always_comb begin
        w_out_data_nxt  = r_out_data;
        w_out_valid_nxt = r_out_valid;
        w_out_last_nxt  = r_out_last;
        w_drop_nxt      = r_drop;

        if (r_out_valid && o_tready) begin
            w_out_valid_nxt = 1'b0;
            w_out_last_nxt  = 1'b0;
        end
        if (w_emit) begin
            w_out_data_nxt  = w_emit_data;
            w_out_valid_nxt = 1'b1;
            w_out_last_nxt  = 1'b1;
            if (r_out_valid && !o_tready && (r_drop != 8'hFF)) begin
                w_drop_nxt = r_drop + 8'd1;
            end
        end
    end

    // State registers; clear behaves like reset but keeps the input open
    always_ff @(posedge ce_clk) begin
        if (ce_rst || clear) begin
            r_ready     <= ~ce_rst;
            r_state     <= c_ST_ACQUIRE;
            r_sign_i    <= 1'b0;
            r_sign_q    <= 1'b0;
            r_known_i   <= 1'b0;
            r_known_q   <= 1'b0;
            r_quad      <= 2'd0;
            r_phase     <= 4'd0;
            r_counter   <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_rot       <= 32'd0;
            r_drop      <= 8'd0;
            r_sync      <= 8'd0;
        end else begin
            r_ready     <= 1'b1;
            r_state     <= w_state_nxt;
            r_sign_i    <= w_sign_i_nxt;
            r_sign_q    <= w_sign_q_nxt;
            r_known_i   <= w_known_i_nxt;
            r_known_q   <= w_known_q_nxt;
            r_quad      <= w_quad_nxt;
            r_phase     <= w_phase_nxt;
            r_counter   <= w_counter_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_last  <= w_out_last_nxt;
            r_rot       <= w_rot_nxt;
            r_drop      <= w_drop_nxt;
            r_sync      <= w_sync_nxt;
        end
    end

    assign i_tready  = r_ready;
    assign o_tdata   = r_out_data;
    assign o_tvalid  = r_out_valid;
    assign o_tlast   = r_out_last;
    assign rot_count = r_rot;
    assign status    = {r_drop, r_sync};

endmodule
`default_nettype wire
